// File: rtl/stump_sequencer.sv
// Stump core instruction sequencer.
// Owns the FETCH/EXECUTE/MEMORY/HALT state register. FETCH and MEMORY are
// held until the memory port acknowledges. The block also evaluates Bcc
// conditions, provides halt/single-step debug control, a sticky memory-timeout
// error and a retired-instruction counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   FETCH   | instruction read on the memory port; IR loads when mem_ready
//   EXECUTE | single-cycle ALU/branch execution, or address phase of LD/ST
//   MEMORY  | LD/ST data access; the instruction retires when mem_ready
//   HALT    | debug stop or bus-error trap; no memory traffic
module stump_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic [3:0]       cc,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [1:0]       state,
  output logic             mem_req,
  output logic             advance,
  output logic             branch_taken,
  output logic             retire,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_MEMORY  = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     cur_state;
  state_t     nxt_state;
  state_t     bnd_state;
  logic [7:0] wait_cnt;
  logic       step_pend;
  logic       timeout;
  logic       is_ldst;
  logic       is_bcc;
  logic       cond_true;
  logic       wait_inc;
  logic       set_err;
  logic       set_step;
  logic       clr_step;

  // Odd condition codes test a flag expression directly, even codes test its
  // inverse; code pair 0/1 uses a constant 0 so that 0 is "always".
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, v, c;
    logic base;
    n = flags[3];
    z = flags[2];
    v = flags[1];
    c = flags[0];
    case (cond[3:1])
      3'd0:    base = 1'b0;
      3'd1:    base = c | z;
      3'd2:    base = c;
      3'd3:    base = z;
      3'd4:    base = v;
      3'd5:    base = n;
      3'd6:    base = n ^ v;
      default: base = (n ^ v) | z;
    endcase
    return cond[0] ? base : ~base;
  endfunction

  assign is_ldst   = (ir[15:13] == 3'b110);
  assign is_bcc    = (ir[15:13] == 3'b111);
  assign cond_true = eval_cond(ir[11:8], cc);
  assign timeout   = (wait_cnt == WAIT_LIM);
  assign state     = cur_state;

  // Instruction boundary: stop if debug asks for it or a single step is owed.
  assign bnd_state = (halt_req || step_pend) ? S_HALT : S_FETCH;

  // Next-state and per-state output decode.
  always_comb begin
    nxt_state    = cur_state;
    mem_req      = 1'b0;
    advance      = 1'b0;
    branch_taken = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    wait_inc     = 1'b0;
    set_err      = 1'b0;
    set_step     = 1'b0;
    clr_step     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        advance = mem_ready;
        if (mem_ready) begin
          nxt_state = S_EXECUTE;
        end else if (timeout) begin
          set_err   = 1'b1;
          nxt_state = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_EXECUTE: begin
        advance      = 1'b1;
        branch_taken = is_bcc & cond_true;
        if (is_ldst) begin
          nxt_state = S_MEMORY;
        end else begin
          retire    = 1'b1;
          clr_step  = 1'b1;
          nxt_state = bnd_state;
        end
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        advance = mem_ready;
        if (mem_ready) begin
          retire    = 1'b1;
          clr_step  = 1'b1;
          nxt_state = bnd_state;
        end else if (timeout) begin
          set_err   = 1'b1;
          nxt_state = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        // A bus error traps here until reset. Dropping halt_req resumes and
        // wins over a coincident step request.
        if (!bus_error) begin
          if (!halt_req) begin
            clr_step  = 1'b1;
            nxt_state = S_FETCH;
          end else if (step_req) begin
            set_step  = 1'b1;
            nxt_state = S_FETCH;
          end
        end
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Consecutive wait-cycle counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (nxt_state != cur_state) begin
      wait_cnt <= 8'd0;
    end else if (wait_inc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky bus error and pending single step.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_error <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      if (set_err) begin
        bus_error <= 1'b1;
      end
      if (set_step) begin
        step_pend <= 1'b1;
      end else if (clr_step) begin
        step_pend <= 1'b0;
      end
    end
  end

  // Retired-instruction counter, wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule
